// File: rtl/ld_wb_router_pkg.sv
// ld_wb_router_pkg: shared types and constants for the load-return path.
//   region_e    : decoded load target (none/DMEM/BIOS/MMIO)
//   state_e     : router FSM encoding
//   F3_*        : load funct3 encodings
//   NIB_*       : address high-nibble region tags
//   is_misaligned(): half/word alignment test used when the error check is built in
package ld_wb_router_pkg;

   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      REGION_NONE = 2'd0,
      REGION_DMEM = 2'd1,
      REGION_BIOS = 2'd2,
      REGION_MMIO = 2'd3
   } region_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RESP = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [3:0] NIB_DMEM_LO = 4'h1;
   localparam logic [3:0] NIB_DMEM_HI = 4'h3;
   localparam logic [3:0] NIB_BIOS    = 4'h4;

   // Half loads need an even address, word loads a 4-byte aligned one.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      case (funct3)
         F3_LH, F3_LHU: mis = off[0];
         F3_LW:         mis = (off != 2'b00);
         default:       mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/ld_wb_router_if.sv
// ld_wb_if: load request / memory return / writeback bundle.
//   master: core side (drives request, stall and memory read data)
//   slave : router side (drives MMIO strobes and writeback result)
interface ld_wb_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned N_MMIO = 4
);
   logic                       req_valid;
   logic [ADDR_W-1:0]          req_addr;
   logic [2:0]                 req_funct3;
   logic                       stall;
   logic [DATA_W-1:0]          dmem_rdata;
   logic [DATA_W-1:0]          bios_rdata;
   logic [N_MMIO*DATA_W-1:0]   mmio_rdata;
   logic [N_MMIO-1:0]          mmio_rd_en;
   logic [DATA_W-1:0]          wb_data;
   logic                       wb_valid;
   logic                       wb_err;
   logic [15:0]                err_cnt;

   modport master (
      output req_valid, req_addr, req_funct3, stall, dmem_rdata, bios_rdata, mmio_rdata,
      input  mmio_rd_en, wb_data, wb_valid, wb_err, err_cnt
   );

   modport slave (
      input  req_valid, req_addr, req_funct3, stall, dmem_rdata, bios_rdata, mmio_rdata,
      output mmio_rd_en, wb_data, wb_valid, wb_err, err_cnt
   );
endinterface

// File: rtl/ld_wb_router_ld_extend.sv
// ld_extend: little-endian byte/half select with sign/zero extension.
//   word     : raw 32-bit source word
//   off      : byte offset (addr[1:0])
//   funct3   : load type
//   result_c : extended load value (combinational)
module ld_extend
   import ld_wb_router_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   input  logic [1:0]        off,
   input  logic [2:0]        funct3,
   output logic [WORD_W-1:0] result_c
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select then extend; unknown funct3 passes the word through.
   always_comb begin
      byte_sel = word[7:0];
      case (off)
         2'd0: byte_sel = word[7:0];
         2'd1: byte_sel = word[15:8];
         2'd2: byte_sel = word[23:16];
         2'd3: byte_sel = word[31:24];
         default: byte_sel = word[7:0];
      endcase
      half_sel = off[1] ? word[31:16] : word[15:0];

      result_c = word;
      case (funct3)
         F3_LB:  result_c = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU: result_c = {24'd0, byte_sel};
         F3_LH:  result_c = {{16{half_sel[15]}}, half_sel};
         F3_LHU: result_c = {16'd0, half_sel};
         default: result_c = word;
      endcase
   end

endmodule

// File: rtl/ld_wb_router.sv
// ld_wb_router: memory-stage load return path.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : ld_wb_if.slave -- load request, stall, DMEM/BIOS/MMIO read data in;
//              mmio_rd_en (combinational one-hot strobe), wb_data/wb_valid/wb_err, err_cnt out
// Optional: define LDROUTE_ERR_CHECK_EN to flag misaligned half/word loads and
// count error events in err_cnt (tied to 0 otherwise).
module ld_wb_router #(
   parameter int unsigned       DATA_W           = 32,
   parameter int unsigned       ADDR_W           = 32,
   parameter int unsigned       N_MMIO           = 4,
   parameter logic [ADDR_W-1:0] MMIO_BASE        = ADDR_W'(32'h8000_0000),
   parameter int unsigned       MMIO_STRIDE_LOG2 = 2
) (
   input logic   clk,
   input logic   rst,
   ld_wb_if.slave bus
);
   import ld_wb_router_pkg::*;

   localparam int unsigned CH_W = (N_MMIO > 1) ? $clog2(N_MMIO) : 1;
   localparam logic [ADDR_W-1:0] STRIDE_MASK = ADDR_W'((64'd1 << MMIO_STRIDE_LOG2) - 64'd1);

   state_e              state_q, state_d;
   region_e             region_q, region_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [1:0]          off_q, off_d;
   logic [2:0]          f3_q, f3_d;
   logic                mis_q, mis_d;
   logic [DATA_W-1:0]   hold_q, hold_d;
   logic [DATA_W-1:0]   wb_data_q, wb_data_d;
   logic                wb_valid_q, wb_valid_d;
   logic                wb_err_q, wb_err_d;

   logic                accept_c;
   region_e             dec_region_c;
   logic [CH_W-1:0]     dec_ch_c;
   logic                dec_mis_c;
   logic [ADDR_W-1:0]   mmio_off_c;
   logic [ADDR_W-1:0]   mmio_idx_c;
   logic [N_MMIO-1:0]   mmio_rd_en_c;
   logic [DATA_W-1:0]   mmio_word_c [N_MMIO];
   logic [DATA_W-1:0]   src_word_c;
   logic [DATA_W-1:0]   ext_word_c;
   logic [DATA_W-1:0]   ext_c;
   logic                bad_c;

   assign accept_c = bus.req_valid && !bus.stall;

   // Request-cycle address decode; DMEM/BIOS take priority over MMIO.
   always_comb begin
      mmio_off_c   = bus.req_addr - MMIO_BASE;
      mmio_idx_c   = mmio_off_c >> MMIO_STRIDE_LOG2;
      dec_ch_c     = CH_W'(mmio_idx_c);
      dec_region_c = REGION_NONE;
      if ((bus.req_addr[ADDR_W-1 -: 4] == NIB_DMEM_LO) ||
          (bus.req_addr[ADDR_W-1 -: 4] == NIB_DMEM_HI)) begin
         dec_region_c = REGION_DMEM;
      end else if (bus.req_addr[ADDR_W-1 -: 4] == NIB_BIOS) begin
         dec_region_c = REGION_BIOS;
      end else if (((mmio_off_c & STRIDE_MASK) == '0) &&
                   (mmio_idx_c < ADDR_W'(N_MMIO))) begin
         dec_region_c = REGION_MMIO;
      end
   end

`ifdef LDROUTE_ERR_CHECK_EN
   assign dec_mis_c = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
   assign dec_mis_c = 1'b0;
`endif

   // One strobe per accepted load; a flagged misaligned load never pops a channel.
   always_comb begin
      mmio_rd_en_c = '0;
      for (int k = 0; k < N_MMIO; k++) begin
         mmio_rd_en_c[k] = accept_c && (dec_region_c == REGION_MMIO) &&
                           (dec_ch_c == CH_W'(k)) && !dec_mis_c;
      end
   end

   // Capture the request attributes needed in the response cycle.
   always_comb begin
      region_d = region_q;
      ch_d     = ch_q;
      off_d    = off_q;
      f3_d     = f3_q;
      mis_d    = mis_q;
      if (accept_c) begin
         region_d = dec_region_c;
         ch_d     = dec_ch_c;
         off_d    = bus.req_addr[1:0];
         f3_d     = bus.req_funct3;
         mis_d    = dec_mis_c;
      end
   end

   // Source word select for the captured region.
   always_comb begin
      for (int i = 0; i < N_MMIO; i++) begin
         mmio_word_c[i] = bus.mmio_rdata[i*DATA_W +: DATA_W];
      end
      case (region_q)
         REGION_DMEM: src_word_c = bus.dmem_rdata;
         REGION_BIOS: src_word_c = bus.bios_rdata;
         REGION_MMIO: src_word_c = mmio_word_c[ch_q];
         default:     src_word_c = '0;
      endcase
   end

   // While held, extraction runs from the hold copy since memories may have moved on.
   assign ext_word_c = (state_q == ST_HOLD) ? hold_q : src_word_c;
   assign bad_c      = (region_q == REGION_NONE) || mis_q;

   ld_extend u_ld_extend (
      .word     (ext_word_c),
      .off      (off_q),
      .funct3   (f3_q),
      .result_c (ext_c)
   );

   // FSM next state and registered writeback outputs.
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      wb_data_d  = '0;
      wb_valid_d = 1'b0;
      wb_err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) state_d = ST_RESP;
         end
         ST_RESP: begin
            wb_valid_d = 1'b1;
            wb_err_d   = bad_c;
            wb_data_d  = bad_c ? '0 : ext_c;
            if (bus.stall) begin
               state_d = ST_HOLD;
               hold_d  = src_word_c;
            end else if (accept_c) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (bus.stall) begin
               wb_valid_d = 1'b1;
               wb_err_d   = bad_c;
               wb_data_d  = bad_c ? '0 : ext_c;
            end else begin
               state_d = accept_c ? ST_RESP : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         region_q   <= REGION_NONE;
         ch_q       <= '0;
         off_q      <= '0;
         f3_q       <= '0;
         mis_q      <= 1'b0;
         hold_q     <= '0;
         wb_data_q  <= '0;
         wb_valid_q <= 1'b0;
         wb_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         region_q   <= region_d;
         ch_q       <= ch_d;
         off_q      <= off_d;
         f3_q       <= f3_d;
         mis_q      <= mis_d;
         hold_q     <= hold_d;
         wb_data_q  <= wb_data_d;
         wb_valid_q <= wb_valid_d;
         wb_err_q   <= wb_err_d;
      end
   end

`ifdef LDROUTE_ERR_CHECK_EN
   logic [15:0] err_cnt_q, err_cnt_d;

   // Count each erroring load once, in its response cycle; saturates.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((state_q == ST_RESP) && bad_c && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) err_cnt_q <= '0;
      else     err_cnt_q <= err_cnt_d;
   end

   assign bus.err_cnt = err_cnt_q;
`else
   assign bus.err_cnt = '0;
`endif

   assign bus.mmio_rd_en = mmio_rd_en_c;
   assign bus.wb_data    = wb_data_q;
   assign bus.wb_valid   = wb_valid_q;
   assign bus.wb_err     = wb_err_q;

endmodule

// File: doc/ld_wb_router.md
Name: ld_wb_router

Overview:
- Parametrised load-return path for the RISC-V core's memory stage.
- Decodes a load address in the request cycle and routes the synchronous read data one cycle later from DMEM, BIOS or one of N_MMIO memory-mapped channels.
- Performs byte/half extraction with sign/zero extension and drives the writeback load operand.
- Holds the returned value across pipeline stalls and pulses per-channel MMIO read strobes exactly once per load.

Parameters:
- DATA_W, 32, data word width; must be 32.
- ADDR_W, 32, address width.
- N_MMIO, 4, number of MMIO read channels, 1..16.
- MMIO_BASE, 32'h8000_0000, address of MMIO channel 0.
- MMIO_STRIDE_LOG2, 2, log2 of the byte spacing between MMIO channels.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  load issued this cycle
- req_addr  in  ADDR_W  load byte address
- req_funct3  in  3  load type (LB=000, LH=001, LW=010, LBU=100, LHU=101)
- stall  in  1  pipeline stall; freezes capture and the held result
- dmem_rdata  in  DATA_W  DMEM word, valid the cycle after the request
- bios_rdata  in  DATA_W  BIOS word, valid the cycle after the request
- mmio_rdata  in  N_MMIO*DATA_W  channel i at bits [i*DATA_W +: DATA_W], valid the cycle after its strobe
- mmio_rd_en  out  N_MMIO  one-hot read strobe (side effects, e.g. UART RX pop)
- wb_data  out  DATA_W  extended load result
- wb_valid  out  1  wb_data is meaningful
- wb_err  out  1  unmapped or misaligned load
- err_cnt  out  16  error counter (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high) clears all registers: wb_data=0, wb_valid=0, wb_err=0, err_cnt=0, mmio_rd_en=0; FSM goes to IDLE.
- Decode (combinational, request cycle):
  - DMEM when addr[31:28] is 4'b0001 or 4'b0011.
  - BIOS when addr[31:28] is 4'b0100.
  - MMIO channel k when addr == MMIO_BASE + (k << MMIO_STRIDE_LOG2) and k < N_MMIO.
  - Anything else is UNMAPPED.
- mmio_rd_en[k] = req_valid & !stall & decoded channel k. Combinational, so exactly one pulse per accepted load; no pulse for any other region.
- Capture: on req_valid & !stall, register region, channel index, addr[1:0] and funct3. No capture while stall is high.
- FSM states:
  - IDLE: accepted request goes to RESP; otherwise stay.
  - RESP: select the source word, extract, and register into wb_data with wb_valid=1.
    - If stall is high: go to HOLD and latch the selected raw word into a hold register, since the memories may change their output.
    - Else if a new request is accepted the same cycle: stay in RESP (back-to-back loads, 1/cycle throughput).
    - Otherwise go to IDLE.
  - HOLD: wb_data, wb_valid and wb_err stay frozen from the hold register. When stall deasserts, go to RESP if req_valid, else IDLE.
- Latency: wb_data is valid at the first clock edge after the response cycle, i.e. two edges after the request.
- wb_valid is high for exactly one cycle per load when there is no stall, and held high through HOLD.
- Extraction:
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Byte lanes are little-endian.
- UNMAPPED load: wb_data=0, wb_valid=1, wb_err=1, no strobe.
- Reset asserted during RESP or HOLD discards the pending result; no wb_valid follows reset.

Optional Feature:
- Macro: LDROUTE_ERR_CHECK_EN.
- Defined:
  - LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, is misaligned: wb_data=0, wb_err=1.
  - A misaligned MMIO load suppresses its strobe.
  - err_cnt is a saturating 16-bit count of wb_err events; it stops at 16'hFFFF.
- Undefined:
  - No misalignment check; extraction uses addr[1:0] as-is.
  - err_cnt is tied to 0. wb_err still flags UNMAPPED loads.

Decomposition:
- Shared package gets:
  - region enum (REGION_NONE, REGION_DMEM, REGION_BIOS, REGION_MMIO);
  - FSM state encoding;
  - funct3 load constants (reused from the opcode definitions);
  - BIOS/DMEM high-nibble constants.
- One sub-module, ld_extend: combinational byte/half select plus sign/zero extension (word, offset, funct3 -> result). It is reusable by the store/forwarding path.

Test Plan:
- LW from 0x1000_0008, dmem_rdata=0xDEAD_BEEF -> wb_data=0xDEAD_BEEF and wb_valid for 1 cycle, 2 edges after the request; mmio_rd_en=0.
- LB at 0x4000_0003, bios_rdata=0x8012_3456 -> wb_data=0xFFFF_FF80; the same access as LBU -> wb_data=0x0000_0080.
- LW at 0x8000_0004 (channel 1), mmio_rdata ch1=0x0000_0041 -> mmio_rd_en=4'b0010 for one cycle, wb_data=0x41. Repeat the request with stall=1 for 3 cycles -> no strobe until stall drops, then one strobe.
- Load at 0x2000_0000 -> wb_err=1, wb_data=0. With LDROUTE_ERR_CHECK_EN, LW at 0x1000_0002 -> wb_err=1, err_cnt=1 and then 2 after a second error.
- Stall asserted in RESP for 4 cycles while dmem_rdata changes to 0x0 -> wb_data stays at the original 0x1234_5678, wb_valid stays 1; back-to-back LW/LH with no stall -> consecutive wb_valid cycles with correct values.
- rst asserted in the RESP cycle -> wb_valid=0 next cycle and no later valid; all outputs are 0.
